// File: rtl/decode_execute_reg.sv
// decode_execute_reg: decode->execute pipeline register, 2-entry skid buffer.
// Ports: clk, reset; flush; in_* decode side + wb_* forward; out_* execute side.
// Optional macro DECODE_EXECUTE_LOAD_USE_STALL_EN adds load_use_stall, stall_count.
module decode_execute_reg #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [REG_ADDR_W-1:0] in_rs1,
    input  logic [REG_ADDR_W-1:0] in_rs2,
    input  logic [XLEN-1:0]       in_data1,
    input  logic [XLEN-1:0]       in_data2,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [ALU_OP_W-1:0]   in_alu_op,
    input  logic [3:0]            in_ctrl,
    input  logic                  wb_write,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [XLEN-1:0]       out_rs1_val,
    output logic [XLEN-1:0]       out_rs2_val,
    output logic [XLEN-1:0]       out_imm,
    output logic [REG_ADDR_W-1:0] out_rs1,
    output logic [REG_ADDR_W-1:0] out_rs2,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [ALU_OP_W-1:0]   out_alu_op,
`ifdef DECODE_EXECUTE_LOAD_USE_STALL_EN
    output logic                  load_use_stall,
    output logic [31:0]           stall_count,
`endif
    output logic [3:0]            out_ctrl
);

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       rs1_val;
        logic [XLEN-1:0]       rs2_val;
        logic [XLEN-1:0]       imm;
        logic [ALU_OP_W-1:0]   alu_op;
        logic [3:0]            ctrl;
    } entry_t;

    entry_t main_q, main_d, skid_q, skid_d;
    entry_t main_r, skid_r, new_e;
    logic   accept, dequeue;

    // x0 reads as zero; a same-cycle writeback wins over the stale RF read.
    function automatic logic [XLEN-1:0] capture(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [XLEN-1:0]       rf
    );
        if (rs == '0)
            return '0;
        if (wb_write && wb_addr == rs)
            return wb_data;
        return rf;
    endfunction

    // Buffered operands track writebacks so they never go stale while waiting.
    function automatic entry_t refresh(input entry_t e);
        entry_t r;
        r = e;
        if (e.valid && wb_write) begin
            if (e.rs1 != '0 && wb_addr == e.rs1)
                r.rs1_val = wb_data;
            if (e.rs2 != '0 && wb_addr == e.rs2)
                r.rs2_val = wb_data;
        end
        return r;
    endfunction

`ifdef DECODE_EXECUTE_LOAD_USE_STALL_EN
    logic        hazard;
    logic [31:0] stall_cnt_q;

    // ctrl[2] is mem_read: hold a dependent instruction behind a load.
    assign hazard = main_q.valid && main_q.ctrl[2] && main_q.rd != '0 &&
                    (main_q.rd == in_rs1 || main_q.rd == in_rs2);
    assign in_ready       = !skid_q.valid && !hazard;
    assign load_use_stall = in_valid && hazard;
    assign stall_count    = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_q <= '0;
        else if (load_use_stall && stall_cnt_q != '1)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end
`else
    assign in_ready = !skid_q.valid;
`endif

    assign accept  = in_valid && in_ready;
    assign dequeue = main_q.valid && out_ready;

    always_comb begin
        new_e         = '0;
        new_e.valid   = 1'b1;
        new_e.pc      = in_pc;
        new_e.rs1     = in_rs1;
        new_e.rs2     = in_rs2;
        new_e.rd      = in_rd;
        new_e.rs1_val = capture(in_rs1, in_data1);
        new_e.rs2_val = capture(in_rs2, in_data2);
        new_e.imm     = in_imm;
        new_e.alu_op  = in_alu_op;
        new_e.ctrl    = in_ctrl;
    end

    always_comb begin
        main_r = refresh(main_q);
        skid_r = refresh(skid_q);
        main_d = main_r;
        skid_d = skid_r;
        if (flush) begin
            // The handshake still completes; its data is simply dropped.
            main_d.valid = 1'b0;
            skid_d.valid = 1'b0;
        end else if (!main_q.valid) begin
            if (accept)
                main_d = new_e;
        end else if (dequeue) begin
            if (skid_q.valid) begin
                main_d       = skid_r;
                skid_d.valid = 1'b0;
                if (accept)
                    skid_d = new_e;
            end else if (accept) begin
                main_d = new_e;
            end else begin
                main_d.valid = 1'b0;
            end
        end else if (accept) begin
            skid_d = new_e;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign out_valid   = main_q.valid;
    assign out_pc      = main_q.pc;
    assign out_rs1_val = main_q.rs1_val;
    assign out_rs2_val = main_q.rs2_val;
    assign out_imm     = main_q.imm;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_rd      = main_q.rd;
    assign out_alu_op  = main_q.alu_op;
    assign out_ctrl    = main_q.ctrl;

endmodule

// File: tb/tb_decode_execute_reg.sv
// tb_decode_execute_reg: directed + random stimulus against a queue model.
// Build with +define+DECODE_EXECUTE_LOAD_USE_STALL_EN to cover the hazard path.
module tb_decode_execute_reg;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [63:0] in_pc, in_data1, in_data2, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [3:0]  in_alu_op, in_ctrl;
    logic        wb_write;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        out_valid, out_ready;
    logic [63:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [3:0]  out_alu_op, out_ctrl;
`ifdef DECODE_EXECUTE_LOAD_USE_STALL_EN
    logic        load_use_stall;
    logic [31:0] stall_count;
`endif

    always #5 clk = ~clk;

    decode_execute_reg dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_data1(in_data1), .in_data2(in_data2),
        .in_imm(in_imm), .in_rd(in_rd),
        .in_alu_op(in_alu_op), .in_ctrl(in_ctrl),
        .wb_write(wb_write), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1_val(out_rs1_val),
        .out_rs2_val(out_rs2_val), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_alu_op(out_alu_op),
`ifdef DECODE_EXECUTE_LOAD_USE_STALL_EN
        .load_use_stall(load_use_stall), .stall_count(stall_count),
`endif
        .out_ctrl(out_ctrl)
    );

    typedef struct {
        logic [63:0] pc, v1, v2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  op, ctrl;
    } ent_t;

    ent_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_stalls = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] opnd(input logic [4:0] rs,
                                         input logic [63:0] rf);
        if (rs == 0) return 64'd0;
        if (wb_write && wb_addr == rs) return wb_data;
        return rf;
    endfunction

    // One clock: compare DUT against the model, advance the model, tick.
    task automatic step();
        logic hz, rdy, acc, deq;
        ent_t e;
        #1;
        hz = 1'b0;
`ifdef DECODE_EXECUTE_LOAD_USE_STALL_EN
        hz = q.size() > 0 && q[0].ctrl[2] && q[0].rd != 0 &&
             (q[0].rd == in_rs1 || q[0].rd == in_rs2);
        chk("load_use_stall", load_use_stall, in_valid && hz);
        chk("stall_count", stall_count, exp_stalls);
`endif
        rdy = q.size() < 2 && !hz;
        chk("in_ready", in_ready, rdy);
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_rs1_val", out_rs1_val, q[0].v1);
            chk("out_rs2_val", out_rs2_val, q[0].v2);
            chk("out_imm", out_imm, q[0].imm);
            chk("out_rs1", out_rs1, q[0].rs1);
            chk("out_rs2", out_rs2, q[0].rs2);
            chk("out_rd", out_rd, q[0].rd);
            chk("out_alu_op", out_alu_op, q[0].op);
            chk("out_ctrl", out_ctrl, q[0].ctrl);
        end
        acc = in_valid && rdy;
        deq = q.size() > 0 && out_ready;
        if (reset) begin
            q.delete();
            exp_stalls = 0;
        end else begin
            if (in_valid && hz && exp_stalls != 32'hFFFF_FFFF)
                exp_stalls++;
            foreach (q[i]) begin
                if (wb_write && q[i].rs1 != 0 && wb_addr == q[i].rs1)
                    q[i].v1 = wb_data;
                if (wb_write && q[i].rs2 != 0 && wb_addr == q[i].rs2)
                    q[i].v2 = wb_data;
            end
            e.pc = in_pc;   e.imm = in_imm;
            e.rs1 = in_rs1; e.rs2 = in_rs2; e.rd = in_rd;
            e.op = in_alu_op; e.ctrl = in_ctrl;
            e.v1 = opnd(in_rs1, in_data1);
            e.v2 = opnd(in_rs2, in_data2);
            if (deq) void'(q.pop_front());
            if (acc) q.push_back(e);
            if (flush) q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc,
                         input logic [4:0] rs1, input logic [63:0] d1,
                         input logic [4:0] rs2, input logic [63:0] d2,
                         input logic [4:0] rd, input logic [3:0] ctrl);
        in_valid  = v;
        in_pc     = pc;
        in_rs1    = rs1;
        in_data1  = d1;
        in_rs2    = rs2;
        in_data2  = d2;
        in_rd     = rd;
        in_ctrl   = ctrl;
        in_imm    = pc ^ 64'hF0F0_0000_0000_1234;
        in_alu_op = pc[5:2];
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        wb_write = 1'b0; wb_addr = '0; wb_data = '0;
        drive(1'b0, 64'h0, 5'd0, 64'h0, 5'd0, 64'h0, 5'd0, 4'h0);
        @(posedge clk); #1;
        step(); step();
        reset = 1'b0;

        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_pc", out_pc, 64'h0);
        chk("rst_rs1_val", out_rs1_val, 64'h0);
        chk("rst_ctrl", out_ctrl, 4'h0);

        drive(1'b1, 64'h100, 5'd3, 64'h11, 5'd0, 64'h99, 5'd4, 4'h8);
        step();
        in_valid = 1'b0;
        chk("single_valid", out_valid, 1'b1);
        chk("single_rs1", out_rs1_val, 64'h11);
        chk("single_rs2", out_rs2_val, 64'h0);
        out_ready = 1'b1;
        step();

        drive(1'b1, 64'h110, 5'd5, 64'hAA, 5'd0, 64'h0, 5'd6, 4'h8);
        wb_write = 1'b1; wb_addr = 5'd5; wb_data = 64'hBB;
        step();
        chk("fwd_capture", out_rs1_val, 64'hBB);
        drive(1'b1, 64'h114, 5'd0, 64'hAA, 5'd0, 64'h0, 5'd6, 4'h8);
        step();
        wb_write = 1'b0;
        in_valid = 1'b0;
        chk("fwd_x0", out_rs1_val, 64'h0);
        step();

        out_ready = 1'b0;
        drive(1'b1, 64'h200, 5'd1, 64'h10, 5'd2, 64'h20, 5'd8, 4'h8);
        step();
        drive(1'b1, 64'h204, 5'd1, 64'h30, 5'd7, 64'h01, 5'd8, 4'h8);
        step();
        chk("bp_in_ready", in_ready, 1'b0);
        drive(1'b1, 64'h208, 5'd3, 64'h40, 5'd4, 64'h50, 5'd8, 4'h8);
        wb_write = 1'b1; wb_addr = 5'd7; wb_data = 64'h77;
        step();
        wb_write = 1'b0;
        chk("bp_hold", in_ready, 1'b0);
        out_ready = 1'b1;
        chk("bp_i0", out_pc, 64'h200);
        step();
        chk("bp_i1", out_pc, 64'h204);
        chk("bp_refresh", out_rs2_val, 64'h77);
        step();
        in_valid = 1'b0;
        chk("bp_i2", out_pc, 64'h208);
        step();

        out_ready = 1'b0;
        drive(1'b1, 64'h300, 5'd1, 64'h1, 5'd2, 64'h2, 5'd3, 4'h8);
        step();
        drive(1'b1, 64'h304, 5'd1, 64'h1, 5'd2, 64'h2, 5'd3, 4'h8);
        step();
        drive(1'b1, 64'h308, 5'd1, 64'h1, 5'd2, 64'h2, 5'd3, 4'h8);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        step(); step();

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 64'h400 + 64'(4 * i), 5'(i + 1), 64'(i * 3),
                  5'(i), 64'(i * 5), 5'd9, 4'h8);
            chk("stream_ready", in_ready, 1'b1);
            step();
            chk("stream_pc", out_pc, 64'h400 + 64'(4 * i));
        end
        in_valid = 1'b0;
        step();

`ifdef DECODE_EXECUTE_LOAD_USE_STALL_EN
        out_ready = 1'b0;
        drive(1'b1, 64'h500, 5'd1, 64'h1, 5'd2, 64'h2, 5'd9, 4'h4);
        step();
        drive(1'b1, 64'h504, 5'd3, 64'h3, 5'd9, 64'h5, 5'd10, 4'h8);
        #1;
        chk("lu_ready", in_ready, 1'b0);
        chk("lu_stall", load_use_stall, 1'b1);
        step();
        chk("lu_count", stall_count, 32'd1);
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        chk("lu_after", out_pc, 64'h504);
        step();
        out_ready = 1'b0;
        drive(1'b1, 64'h600, 5'd1, 64'h1, 5'd2, 64'h2, 5'd0, 4'h4);
        step();
        drive(1'b1, 64'h604, 5'd0, 64'h3, 5'd0, 64'h5, 5'd10, 4'h8);
        #1;
        chk("lu_x0_ready", in_ready, 1'b1);
        chk("lu_x0_stall", load_use_stall, 1'b0);
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        step(); step();
`endif

        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 24) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 3) != 0, {$urandom, $urandom},
                  5'($urandom_range(0, 7)), {$urandom, $urandom},
                  5'($urandom_range(0, 7)), {$urandom, $urandom},
                  5'($urandom_range(0, 7)), 4'($urandom));
            wb_write = ($urandom_range(0, 1) == 1);
            wb_addr  = 5'($urandom_range(0, 7));
            wb_data  = {$urandom, $urandom};
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
